// File: rtl/prbs_checker_multi.sv
// rtl/prbs_checker_multi.sv - multi-polynomial PRBS checker with self-sync, lock tracking and count snapshots
// The LFSR holds received bits in SEARCH and free-runs its own prediction in LOCKED.
module prbs_checker_multi #(
  parameter int CNT_W     = 32,
  parameter int LOCK_CNT  = 16,
  parameter int BLOCK_LEN = 1024,
  parameter int LOSS_ERRS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             get_word,
  output logic             locked,
  output logic             send_data,
  output logic [CNT_W-1:0] error_bits_out,
  output logic [CNT_W-1:0] total_bits_out,
  output logic [7:0]       lock_loss_cnt
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(BLOCK_LEN + 1);

  typedef enum logic {SEARCH, LOCKED_ST} state_t;
  state_t state_q, state_d;

  logic [1:0]       mode_q;
  logic [30:0]      lfsr_q;
  logic [4:0]       fill_q;
  logic [MW-1:0]    match_q;
  logic [BW-1:0]    blk_bits_q, blk_err_q, blk_bits_inc, blk_err_inc;
  logic [CNT_W-1:0] total_q, error_q, total_nxt, error_nxt;
  logic [4:0]       order, tap_a, tap_b;
  logic             p, mismatch, mode_change, filled, match_full;
  logic             blk_end, lose, count_en, leave_lock;

  // Tap indices are exponent-1 because lfsr_q[0] is the most recent bit.
  always_comb begin
    case (mode)
      2'd0:    begin order = 5'd7;  tap_a = 5'd6;  tap_b = 5'd5;  end
      2'd1:    begin order = 5'd15; tap_a = 5'd14; tap_b = 5'd13; end
      2'd2:    begin order = 5'd23; tap_a = 5'd22; tap_b = 5'd17; end
      default: begin order = 5'd31; tap_a = 5'd30; tap_b = 5'd27; end
    endcase
  end

  assign p            = lfsr_q[tap_a] ^ lfsr_q[tap_b];
  assign mismatch     = bit_in ^ p;
  assign mode_change  = (mode != mode_q);
  assign filled       = (fill_q >= order);
  assign match_full   = filled && !mismatch && (match_q == MW'(LOCK_CNT - 1));
  assign blk_bits_inc = blk_bits_q + BW'(1);
  assign blk_err_inc  = blk_err_q + BW'(mismatch);
  assign blk_end      = (blk_bits_inc == BW'(BLOCK_LEN));
  assign lose         = blk_end && (blk_err_inc >= BW'(LOSS_ERRS));

  always_comb begin
    state_d  = state_q;
    count_en = 1'b0;
    if (mode_change) begin
      state_d = SEARCH;
    end else if (bit_valid) begin
      case (state_q)
        SEARCH: if (match_full) state_d = LOCKED_ST;
        LOCKED_ST: begin
          count_en = 1'b1;
          if (lose) state_d = SEARCH;
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  assign leave_lock = (state_q == LOCKED_ST) && (state_d == SEARCH);
  assign locked     = (state_q == LOCKED_ST);

  // Saturating counters; the error counter saturates independently of total.
  assign total_nxt = (&total_q) ? total_q : total_q + CNT_W'(count_en);
  assign error_nxt = (&error_q) ? error_q : error_q + CNT_W'(count_en & mismatch);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= SEARCH;
      mode_q         <= 2'd0;
      lfsr_q         <= '0;
      fill_q         <= '0;
      match_q        <= '0;
      blk_bits_q     <= '0;
      blk_err_q      <= '0;
      total_q        <= '0;
      error_q        <= '0;
      send_data      <= 1'b0;
      error_bits_out <= '0;
      total_bits_out <= '0;
      lock_loss_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode;
      send_data <= get_word;

      if (get_word) begin
        total_bits_out <= total_nxt;
        error_bits_out <= error_nxt;
        total_q        <= '0;
        error_q        <= '0;
      end else begin
        total_q <= total_nxt;
        error_q <= error_nxt;
      end

      if (leave_lock && (lock_loss_cnt != 8'hFF)) lock_loss_cnt <= lock_loss_cnt + 8'd1;

      if (bit_valid)
        lfsr_q <= {lfsr_q[29:0], ((state_q == LOCKED_ST) && !mode_change) ? p : bit_in};

      if (mode_change || leave_lock) begin
        fill_q  <= '0;
        match_q <= '0;
      end else if (bit_valid && (state_q == SEARCH)) begin
        if (!filled)                fill_q  <= fill_q + 5'd1;
        else if (mismatch)          match_q <= '0;
        else if (match_full)        match_q <= '0;
        else                        match_q <= match_q + MW'(1);
      end

      if ((state_d != LOCKED_ST) || (count_en && blk_end)) begin
        blk_bits_q <= '0;
        blk_err_q  <= '0;
      end else if (count_en) begin
        blk_bits_q <= blk_bits_inc;
        blk_err_q  <= blk_err_inc;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker_multi.sv
// tb/tb_prbs_checker_multi.sv - directed self-checking bench for prbs_checker_multi
// Stimulus is a reference PRBS generator with optional bit flips or inversion.
module tb_prbs_checker_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        get_word = 1'b0;
  logic        locked, send_data;
  logic [31:0] error_bits_out, total_bits_out;
  logic [7:0]  lock_loss_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [30:0] g;
  logic [1:0]  gmode;
  logic [31:0] e1, e2;

  prbs_checker_multi dut (
    .clk            (clk),
    .rst            (rst),
    .mode           (mode),
    .bit_in         (bit_in),
    .bit_valid      (bit_valid),
    .get_word       (get_word),
    .locked         (locked),
    .send_data      (send_data),
    .error_bits_out (error_bits_out),
    .total_bits_out (total_bits_out),
    .lock_loss_cnt  (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic seed_gen(input logic [1:0] m);
    gmode = m;
    g     = 31'h2A5B3C4D;
  endtask

  task automatic gen_bit(output logic b);
    case (gmode)
      2'd0:    b = g[6]  ^ g[5];
      2'd1:    b = g[14] ^ g[13];
      2'd2:    b = g[22] ^ g[17];
      default: b = g[30] ^ g[27];
    endcase
    g = {g[29:0], b};
  endtask

  task automatic step(input logic v, input logic flip, input logic gw);
    logic b;
    @(negedge clk);
    b = 1'b0;
    if (v) gen_bit(b);
    bit_valid = v;
    bit_in    = v ? (b ^ flip) : 1'b0;
    get_word  = gw;
  endtask

  task automatic run(input int n, input int period, input logic inv, input logic gw_last);
    for (int i = 0; i < n; i++)
      step(1'b1, inv | ((period > 0) && (((i + 1) % period) == 0)), gw_last && (i == n - 1));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0);
  endtask

  // Reset, then one extra cycle so any mode change is absorbed before stimulus.
  task automatic do_reset(input logic [1:0] m);
    @(negedge clk);
    rst = 1'b1; mode = m; bit_valid = 1'b0; get_word = 1'b0; bit_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    do_reset(2'd0);
    chk("rst_locked", locked, 0);
    chk("rst_send", send_data, 0);
    chk("rst_err", error_bits_out, 0);
    chk("rst_tot", total_bits_out, 0);
    chk("rst_loss", lock_loss_cnt, 0);

    // 1: clean PRBS7, lock on the 23rd bit, then 1000 counted bits
    seed_gen(2'd0);
    run(22, 0, 1'b0, 1'b0); idle();
    chk("s1_not_yet_locked", locked, 0);
    run(1, 0, 1'b0, 1'b0); idle();
    chk("s1_locked", locked, 1);
    run(1000, 0, 1'b0, 1'b1); idle();
    chk("s1_send", send_data, 1);
    chk("s1_err", error_bits_out, 0);
    chk("s1_tot", total_bits_out, 1000);
    idle();
    chk("s1_send_low", send_data, 0);
    chk("s1_tot_hold", total_bits_out, 1000);

    // 2: PRBS31 with one flipped bit per 100
    do_reset(2'd3);
    seed_gen(2'd3);
    run(47, 0, 1'b0, 1'b0); idle();
    chk("s2_locked", locked, 1);
    run(10000, 100, 1'b0, 1'b1); idle();
    chk("s2_err", error_bits_out, 100);
    chk("s2_tot", total_bits_out, 10000);
    chk("s2_still_locked", locked, 1);
    chk("s2_loss", lock_loss_cnt, 0);

    // 3: PRBS15 then inverted stream; loss after exactly one full block
    do_reset(2'd1);
    seed_gen(2'd1);
    run(31, 0, 1'b0, 1'b0); idle();
    chk("s3_locked", locked, 1);
    run(1023, 0, 1'b1, 1'b0); idle();
    chk("s3_locked_1023", locked, 1);
    run(1, 0, 1'b1, 1'b0); idle();
    chk("s3_unlocked", locked, 0);
    chk("s3_loss", lock_loss_cnt, 1);
    run(50, 0, 1'b1, 1'b1); idle();
    chk("s3_tot_frozen", total_bits_out, 1024);
    chk("s3_err_frozen", error_bits_out, 1024);
    chk("s3_no_relock", locked, 0);

    // 4: mode switch while locked, then stream switch to relock
    do_reset(2'd0);
    seed_gen(2'd0);
    run(23, 0, 1'b0, 1'b0); idle();
    chk("s4_locked", locked, 1);
    @(negedge clk); mode = 2'd1;
    idle();
    chk("s4_search", locked, 0);
    chk("s4_loss", lock_loss_cnt, 1);
    run(200, 0, 1'b0, 1'b0); idle();
    chk("s4_no_relock", locked, 0);
    seed_gen(2'd1);
    run(40, 0, 1'b0, 1'b0); idle();
    chk("s4_relock", locked, 1);
    run(100, 0, 1'b0, 1'b1); idle();
    chk("s4_err", error_bits_out, 0);
    chk("s4_loss_kept", lock_loss_cnt, 1);

    // 6: one-cycle reset mid-lock, then relock as in scenario 1
    @(negedge clk);
    rst = 1'b1; mode = 2'd0; bit_valid = 1'b0; get_word = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("s6_locked", locked, 0);
    chk("s6_send", send_data, 0);
    chk("s6_err", error_bits_out, 0);
    chk("s6_tot", total_bits_out, 0);
    chk("s6_loss", lock_loss_cnt, 0);
    seed_gen(2'd0);
    run(22, 0, 1'b0, 1'b0); idle();
    chk("s6_not_yet_locked", locked, 0);
    run(1, 0, 1'b0, 1'b0); idle();
    chk("s6_relock", locked, 1);

    // 5: toggling bit_valid, snapshot on a valid error bit
    do_reset(2'd0);
    seed_gen(2'd0);
    run(23, 0, 1'b0, 1'b0); idle();
    chk("s5_locked", locked, 1);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, 1'b0);
      idle();
    end
    step(1'b1, 1'b1, 1'b1); idle();
    chk("s5_send1", send_data, 1);
    chk("s5_tot1", total_bits_out, 10);
    chk("s5_err1", error_bits_out, 1);
    e1 = error_bits_out;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, (i == 3) || (i == 10), 1'b0);
      idle();
    end
    step(1'b0, 1'b0, 1'b1); idle();
    chk("s5_send2", send_data, 1);
    chk("s5_tot2", total_bits_out, 10);
    chk("s5_err2", error_bits_out, 2);
    e2 = error_bits_out;
    chk("s5_err_sum", e1 + e2, 3);
    chk("s5_loss", lock_loss_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_checker_multi.md
Name: prbs_checker_multi

Overview:
- Parametrised successor to the fixed PRBS receiver. Checks a serial bitstream against a run-time selectable PRBS polynomial (PRBS7/15/23/31).
- Self-synchronises by seeding its local LFSR from the incoming stream, tracks lock and loss-of-lock, and counts total and errored bits.
- Delivers snapshots of the counts on a request/strobe handshake to the host readout logic downstream.

Parameters:
CNT_W, 32, width of the total, error and snapshot counters.
LOCK_CNT, 16, consecutive matching bits required in SEARCH before declaring lock.
BLOCK_LEN, 1024, bits per loss-of-lock evaluation block in LOCKED.
LOSS_ERRS, 64, errors within one block that force return to SEARCH.

Ports:
clk  in  1  system clock, 100 MHz.
rst  in  1  synchronous, active-high reset.
mode  in  2  polynomial select: 0 x^7+x^6+1, 1 x^15+x^14+1, 2 x^23+x^18+1, 3 x^31+x^28+1.
bit_in  in  1  received serial bit.
bit_valid  in  1  bit_in is valid this cycle.
get_word  in  1  snapshot request. A one-cycle pulse is sufficient.
locked  out  1  checker in LOCKED state.
send_data  out  1  one-cycle strobe: snapshot outputs updated.
error_bits_out  out  CNT_W  errored bits in the last snapshot interval.
total_bits_out  out  CNT_W  bits checked in the last snapshot interval.
lock_loss_cnt  out  8  number of LOCKED->SEARCH transitions since reset. Saturates at 255.

Behaviour:
- Reset (synchronous): state=SEARCH. LFSR, fill count, match count, block counters and all counters cleared. All outputs = 0.
- LFSR: 31-bit shift register. Order N = 7/15/23/31 per mode. Predicted bit p = reg[tapA] ^ reg[tapB] (taps per polynomial, 1-based exponents). Shift occurs only on bit_valid.
- SEARCH:
  - Each valid bit shifts bit_in into the register (self-seeding).
  - The fill count increments to N and then holds.
  - Once fill>=N, each valid bit compares p with bit_in. A match increments the match count; a mismatch clears it to 0.
  - When the match count reaches LOCK_CNT, go to LOCKED. locked=1 from the next cycle.
  - No bits are counted in SEARCH.
- LOCKED:
  - The register shifts in p (free-running local generator), not bit_in.
  - Each valid bit: total+1; if bit_in != p, error+1 and block_err+1.
  - block_bits increments. At block_bits==BLOCK_LEN, evaluate: if block_err>=LOSS_ERRS, go to SEARCH, increment lock_loss_cnt, and clear fill and match counts. Block counters clear in either case.
- mode change: any cycle where mode differs from its registered value forces SEARCH and clears fill, match and block counters. Total and error counters are kept. lock_loss_cnt increments only if the state was LOCKED.
- Counters saturate at all-ones (no wrap). If total saturates, error is still allowed to increment up to its own saturation.
- Snapshot:
  - On the cycle get_word=1, the snapshot captures counter value plus this cycle's increment.
  - The counters restart at 0 next cycle, so no bit is lost or double-counted.
  - error_bits_out/total_bits_out update and send_data=1 one cycle after get_word is sampled.
  - A get_word held high for k cycles yields k snapshots.
  - Snapshot outputs hold between strobes.
- Lock loss and get_word in the same cycle: the snapshot is taken normally; the state transition still happens.
- Reset mid-operation overrides everything. The next cycle is identical to post-reset.

Test Plan:
1. Clean PRBS7 stream, mode=0, continuous bit_valid. -> locked rises within 7+16+2 cycles of the first valid bit. After 1000 further bits, a get_word gives error_bits_out=0 and total_bits_out=1000±1 (exact per capture cycle), with send_data high one cycle.
2. PRBS31, mode=3. Inject 1 flipped bit every 100 bits for 10000 locked bits. -> error_bits_out=100, total_bits_out=10000, locked stays 1, lock_loss_cnt=0.
3. Locked on PRBS15, then invert the stream (every bit an error). -> after the first complete 1024-bit block, locked=0 and lock_loss_cnt=1. Counters freeze while in SEARCH.
4. Locked PRBS7, switch mode to 1 with the stream still PRBS7. -> immediate SEARCH, lock_loss_cnt=1, no relock while the match count keeps failing. Switch the stream to PRBS15 -> relock.
5. bit_valid toggling 1/0, get_word pulsed on a valid error bit. -> that bit is included in the snapshot; the next snapshot excludes it; the sum over snapshots equals the injected errors.
6. Assert rst for 1 cycle mid-lock. -> next cycle locked=0, all outputs 0, send_data=0; relock occurs as in scenario 1.
